// File: rtl/uart_tx_serializer_if.sv
// Bus bundle between the UART TX serializer, the 16x9 TX FIFO and the UART control registers.
interface uart_tx_serializer_if #(
   parameter int DIV_W = 16
);
   logic             Enable;
   logic [DIV_W-1:0] BaudDiv;
   logic [1:0]       DataBits;
   logic [1:0]       ParityMode;
   logic             TwoStop;
   logic             FifoEmpty;
   logic [8:0]       FifoData;
   logic             FifoRead;
   logic             Tx;
   logic             Busy;
   logic             FrameDone;

   modport master (
      output Enable, BaudDiv, DataBits, ParityMode, TwoStop, FifoEmpty, FifoData,
      input  FifoRead, Tx, Busy, FrameDone
   );

   modport slave (
      input  Enable, BaudDiv, DataBits, ParityMode, TwoStop, FifoEmpty, FifoData,
      output FifoRead, Tx, Busy, FrameDone
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: drains the TX FIFO one word per frame and serialises it onto Tx.
// Optional line-break state is built only when UART_TX_BREAK_EN is defined.
module uart_tx_serializer #(
   parameter int DIV_W = 16
) (
   input  logic                Clock,
   input  logic                Reset_n,
`ifdef UART_TX_BREAK_EN
   input  logic                Break,
`endif
   uart_tx_serializer_if.slave bus
);

`ifdef UART_TX_BREAK_EN
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`endif

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic             r_stop_idx;
   logic [7:0]       r_shift;
   logic [7:0]       w_shift_nxt;
   logic [1:0]       r_dbits;
   logic [1:0]       r_pmode;
   logic             r_two_stop;
   logic             r_par_bit;
   logic             r_tx;
   logic             r_fifo_read;
   logic             w_bit_end;
   logic             w_last_data;
   logic             w_last_stop;
   logic             w_start_ok;
   logic             w_timed;
   logic             w_frame_done;
   logic             w_tx_nxt;

   // Parity / 9th bit for the frame; bits above the active width are masked out.
   function automatic logic f_parity_bit(input logic [8:0] data,
                                         input logic [1:0] dbits,
                                         input logic [1:0] pmode);
      logic [7:0] mask;
      logic       x;
      mask = 8'hFF >> (2'd3 - dbits);
      x    = ^(data[7:0] & mask);
      case (pmode)
         2'b01:   f_parity_bit = x;
         2'b10:   f_parity_bit = ~x;
         2'b11:   f_parity_bit = data[8];
         default: f_parity_bit = 1'b0;
      endcase
   endfunction

   assign w_bit_end   = (r_cnt == r_div);
   assign w_last_data = (r_idx == ({1'b0, r_dbits} + 3'd4));
   assign w_last_stop = (r_stop_idx == r_two_stop);
   assign w_start_ok  = bus.Enable && !bus.FifoEmpty;
   assign w_timed     = (r_state == S_START) || (r_state == S_DATA) ||
                        (r_state == S_PARITY) || (r_state == S_STOP);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_frame_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_state_nxt = S_FETCH;
`ifdef UART_TX_BREAK_EN
            if (Break) w_state_nxt = S_BREAK;
`endif
         end
         S_FETCH: w_state_nxt = S_LOAD;
         S_LOAD:  w_state_nxt = S_START;
         S_START: if (w_bit_end) w_state_nxt = S_DATA;
         S_DATA: begin
            if (w_bit_end && w_last_data)
               w_state_nxt = (r_pmode != 2'b00) ? S_PARITY : S_STOP;
         end
         S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
         S_STOP: begin
            if (w_bit_end && w_last_stop) begin
               w_frame_done = 1'b1;
               w_state_nxt  = w_start_ok ? S_FETCH : S_IDLE;
`ifdef UART_TX_BREAK_EN
               if (Break) w_state_nxt = S_BREAK;
`endif
            end
         end
`ifdef UART_TX_BREAK_EN
         S_BREAK: if (!Break) w_state_nxt = S_IDLE;
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Tx is registered from the next state so the line changes exactly with the state.
   always_comb begin
      w_shift_nxt = r_shift;
      if (r_state == S_LOAD)
         w_shift_nxt = bus.FifoData[7:0];
      else if ((r_state == S_DATA) && w_bit_end)
         w_shift_nxt = {1'b0, r_shift[7:1]};

      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         S_START:  w_tx_nxt = 1'b0;
         S_DATA:   w_tx_nxt = w_shift_nxt[0];
         S_PARITY: w_tx_nxt = r_par_bit;
`ifdef UART_TX_BREAK_EN
         S_BREAK:  w_tx_nxt = 1'b0;
`endif
         default:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_tx        <= 1'b1;
         r_fifo_read <= 1'b0;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_stop_idx  <= 1'b0;
         r_div       <= '0;
         r_dbits     <= '0;
         r_pmode     <= '0;
         r_two_stop  <= 1'b0;
         r_par_bit   <= 1'b0;
      end else begin
         r_tx        <= w_tx_nxt;
         r_fifo_read <= (w_state_nxt == S_FETCH);
         r_shift     <= w_shift_nxt;

         // Frame configuration is frozen here until the next word is loaded.
         if (r_state == S_LOAD) begin
            r_div      <= (bus.BaudDiv == '0) ? DIV_W'(1) : bus.BaudDiv;
            r_dbits    <= bus.DataBits;
            r_pmode    <= bus.ParityMode;
            r_two_stop <= bus.TwoStop;
            r_par_bit  <= f_parity_bit(bus.FifoData, bus.DataBits, bus.ParityMode);
         end

         if (w_timed) r_cnt <= w_bit_end ? '0 : r_cnt + DIV_W'(1);
         else         r_cnt <= '0;

         if (r_state != S_DATA) r_idx <= '0;
         else if (w_bit_end)    r_idx <= w_last_data ? 3'd0 : r_idx + 3'd1;

         if (r_state != S_STOP) r_stop_idx <= 1'b0;
         else if (w_bit_end)    r_stop_idx <= ~r_stop_idx;
      end
   end

   assign bus.Tx        = r_tx;
   assign bus.FifoRead  = r_fifo_read;
   assign bus.Busy      = (r_state != S_IDLE);
   assign bus.FrameDone = w_frame_done;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit engine that sits directly downstream of the 16x9 TX FIFO and drains it one word at a time.
- Issues a single-cycle read strobe to the FIFO, captures the registered 9-bit output word, and serialises it onto the Tx line.
- Frame format: start bit, 5-8 data bits LSB first, optional parity or 9th bit, then 1 or 2 stop bits.
- Frame format and baud divisor come from the UART control registers.

Parameters:
- DIV_W, 16, width of the baud divisor; bit period = BaudDiv+1 clocks.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Enable  in  1  transmitter enable; gates the start of new frames only.
- BaudDiv  in  DIV_W  clocks per bit minus one; legal range >=1.
- DataBits  in  2  data bit count: 00=5, 01=6, 10=7, 11=8.
- ParityMode  in  2  00=none, 01=even, 10=odd, 11=send FIFO bit 8 as the 9th bit.
- TwoStop  in  1  1 = two stop bits, 0 = one stop bit.
- FifoEmpty  in  1  FIFO Empty flag.
- FifoData  in  9  FIFO DataOut; valid the cycle after FifoRead.
- FifoRead  out  1  FIFO read strobe; registered, one cycle per word.
- Tx  out  1  serial output; idles high.
- Busy  out  1  high in every state except IDLE.
- FrameDone  out  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state=IDLE, Tx=1, FifoRead=0, Busy=0, FrameDone=0.
  - All counters and the shift register cleared.
  - Reset mid-frame aborts the frame immediately; Tx returns high without waiting for a clock edge.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: Tx=1. Enable && !FifoEmpty -> FETCH.
- FETCH: exactly one cycle; FifoRead=1 only in this state. -> LOAD.
- LOAD: one cycle.
  - Capture FifoData[8:0], BaudDiv, DataBits, ParityMode and TwoStop into frame registers.
  - Config changes mid-frame have no effect until the next LOAD.
  - -> START.
- Bit timing:
  - Bit counter counts 0..BaudDivLatched, so each bit is held BaudDivLatched+1 clocks.
  - The state/bit advances when the counter equals BaudDivLatched; the counter then wraps to 0.
- START: Tx=0 for one bit period. -> DATA.
- DATA:
  - Tx = shift register LSB, shifted right once per bit.
  - Data index counts 0..N-1, where N = DataBits+5.
  - After bit N-1: -> PARITY if ParityMode!=00, else -> STOP.
- PARITY: one bit period.
  - Even: Tx = XOR of the N active data bits.
  - Odd: Tx = inverse of that XOR.
  - Mode 11: Tx = captured bit 8.
  - Data bits above N-1 never affect parity.
  - -> STOP.
- STOP: Tx=1 for 1 or 2 bit periods per TwoStop.
  - On the final clock: FrameDone=1.
  - Next state is FETCH if Enable && !FifoEmpty, else IDLE.
  - Back-to-back frames therefore carry exactly 2 extra high clocks (FETCH, LOAD) between the stop bit and the next start bit.
- Enable:
  - Deassertion mid-frame completes the current frame, then goes to IDLE.
  - Assertion only has effect in IDLE or on the final STOP clock.
- Empty FIFO: stays in IDLE and never asserts FifoRead.
- Overflow: the FIFO overflow state is irrelevant here; the block reads only while FifoEmpty=0.
- BaudDiv=0 is illegal; the block must treat it as 1.
- Outputs Tx and FifoRead come straight from flops (no combinational glitches).

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined: adds input port Break (1 bit).
  - Break high in IDLE -> state BREAK: Tx=0, Busy=1, no FIFO reads.
  - Exit to IDLE on the first clock with Break low; Tx returns to 1 on that clock.
  - Break asserted mid-frame is deferred until the frame's FrameDone; it takes priority over FETCH.
- Not defined: no Break port and no BREAK state; the behaviour is otherwise identical.

Test Plan:
- Basic 8N1 frame:
  - Stimulus: BaudDiv=3, 8N1, FIFO holds 0x0A5, Enable=1.
  - Response: FifoRead pulses once. Tx = 0 then 1,0,1,0,0,1,0,1 then 1, each bit 4 clocks (40 clocks total). FrameDone pulses on clock 40.
- Parity modes:
  - Even parity, 8 bits, 0x0A5 -> parity bit 0.
  - Odd parity -> parity bit 1.
  - Mode 11 with word 0x1A5 -> 9th bit 1.
- Short word, two stop bits:
  - Stimulus: 5 data bits, TwoStop=1, word 0x1FF, BaudDiv=1.
  - Response: Tx = start, 5 ones, 2 stop bits (16 clocks). Bits 5-8 of the word are ignored.
- Back-to-back frames:
  - Stimulus: FIFO holds 3 words, Enable held high.
  - Response: 3 FifoRead pulses, 2-clock high gap between frames, Busy stays high throughout, FIFO ends Empty.
- Enable drop and reset:
  - Enable dropped mid-DATA -> frame completes, then IDLE with no further FifoRead.
  - Reset_n pulsed low mid-frame -> Tx=1 and Busy=0 immediately (asynchronous).
- Break (UART_TX_BREAK_EN defined):
  - Break held 10 clocks in IDLE -> Tx=0 for those 10 clocks, FifoRead stays 0.
